// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions (package cpu_pkg): word width, bubble/reset defaults, IF/ID record.
package cpu_pkg;
    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INS  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] ins;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            exc;
    } if_id_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: pipeline control in, ROM address/data, IF/ID register out.
interface instr_fetch_if;
    import cpu_pkg::*;

    logic            stall_i;
    logic            flush_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_target_i;
    logic [XLEN-1:0] rom_addr_o;
    logic [XLEN-1:0] rom_ins_i;
    logic [XLEN-1:0] pc_o;
    logic            id_valid_o;
    logic [XLEN-1:0] id_ins_o;
    logic [XLEN-1:0] id_pc_o;
    logic [XLEN-1:0] id_pc_plus4_o;
    logic            id_exc_o;

    modport slave (
        input  stall_i, flush_i, redirect_i, redirect_target_i, rom_ins_i,
        output rom_addr_o, pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus4_o, id_exc_o
    );

    modport master (
        output stall_i, flush_i, redirect_i, redirect_target_i, rom_ins_i,
        input  rom_addr_o, pc_o, id_valid_o, id_ins_o, id_pc_o, id_pc_plus4_o, id_exc_o
    );
endinterface

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC select: redirect > stall > sequential.
// FETCH_EXC_EN keeps raw target low bits so misaligned fetches can be flagged downstream.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] next_pc_o
);
    logic [XLEN-1:0] target_w;

`ifdef FETCH_EXC_EN
    assign target_w = target_i;
`else
    assign target_w = target_i & ~XLEN'(3);
`endif

    // Flush does not affect the PC: flush+stall holds, flush alone advances.
    always_comb begin
        next_pc_o = pc_i + XLEN'(4);
        if (redirect_i) begin
            next_pc_o = target_w;
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, ROM word address, IF/ID capture with stall/flush/redirect.
// Optional macro FETCH_EXC_EN enables misaligned/out-of-range fetch exceptions.
module instr_fetch #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int                       ROM_DEPTH = 256,
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INS   = cpu_pkg::NOP_INS
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);
    import cpu_pkg::*;

    localparam int AW = $clog2(ROM_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          id_q, id_d;

    fetch_next_pc u_next_pc (
        .pc_i      (pc_q),
        .stall_i   (bus.stall_i),
        .redirect_i(bus.redirect_i),
        .target_i  (bus.redirect_target_i),
        .next_pc_o (pc_d)
    );

    function automatic if_id_t bubble(input logic [XLEN-1:0] pc);
        if_id_t b;
        b.valid    = 1'b0;
        b.ins      = NOP_INS;
        b.pc       = pc;
        b.pc_plus4 = pc + XLEN'(4);
        b.exc      = 1'b0;
        return b;
    endfunction

`ifdef FETCH_EXC_EN
    function automatic logic fetch_exc(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00) || ((pc >> 2) >= XLEN'(ROM_DEPTH));
    endfunction
`endif

    always_comb begin
        id_d = id_q;
        if (bus.redirect_i || bus.flush_i) begin
            id_d = bubble(pc_q);
        end else if (!bus.stall_i) begin
            id_d.valid    = 1'b1;
            id_d.ins      = bus.rom_ins_i;
            id_d.pc       = pc_q;
            id_d.pc_plus4 = pc_q + XLEN'(4);
            id_d.exc      = 1'b0;
`ifdef FETCH_EXC_EN
            if (fetch_exc(pc_q)) begin
                id_d.ins = NOP_INS;
                id_d.exc = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
            id_q <= '{valid: 1'b0, ins: NOP_INS, pc: '0, pc_plus4: '0, exc: 1'b0};
        end else begin
            pc_q <= pc_d;
            id_q <= id_d;
        end
    end

    // Upper PC bits are dropped so the ROM index wraps modulo ROM_DEPTH.
    assign bus.rom_addr_o    = {{(XLEN-AW){1'b0}}, pc_q[AW+1:2]};
    assign bus.pc_o          = pc_q;
    assign bus.id_valid_o    = id_q.valid;
    assign bus.id_ins_o      = id_q.ins;
    assign bus.id_pc_o       = id_q.pc;
    assign bus.id_pc_plus4_o = id_q.pc_plus4;
    assign bus.id_exc_o      = id_q.exc;
endmodule
